rr_onehot_arbiter: RTL

Round-robin arbiter that shares one resource among NUM_REQ requesters and drives a registered one-hot grant vector. Ownership is held until the owner releases the grant or a hold-time limit expires. A built-in one-hot checker watches the grant vector and flags any illegal encoding. The block sits in front of any shared datapath that consumes one-hot select lines.

---
 rtl/rr_onehot_arbiter_if.sv | 18 +
 rtl/rr_onehot_arbiter.sv | 103 ++++++++++
 2 files changed

// File: rtl/rr_onehot_arbiter_if.sv
// Request/grant bundle between requesters and the round-robin arbiter.
// The master drives requests and releases; the slave (arbiter) drives the grant side.
interface rr_onehot_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0] req;
    logic               done;
    logic [NUM_REQ-1:0] gnt;
    logic [IW-1:0]      gnt_id;
    logic               busy;
    logic               timeout;
    logic               err;

    modport master (output req, done, input gnt, gnt_id, busy, timeout, err);
    modport slave  (input req, done, output gnt, gnt_id, busy, timeout, err);
endinterface

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter with registered one-hot grant, optional hold limit
// and a sticky one-hot encoding checker.
module rr_onehot_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    rr_onehot_arbiter_if.slave   bus
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state;
    logic [IW-1:0]      ptr;
    logic [HW-1:0]      hold_cnt;
    logic [NUM_REQ-1:0] gnt;
    logic [IW-1:0]      gnt_id;
    logic               timeout;
    logic               err;

    // Returns {found, index} of the first set bit at or after start, wrapping.
    function automatic logic [IW:0] pick(input logic [NUM_REQ-1:0] r, input logic [IW-1:0] start);
        logic [IW:0] res;
        int          idx;
        res = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(start) + i) % NUM_REQ;
            if (!res[IW] && r[idx]) res = {1'b1, IW'(idx)};
        end
        return res;
    endfunction

    logic [IW-1:0] nxt_ptr;
    logic          release_now;
    logic          revoke;
    logic [IW:0]   arb_idle;
    logic [IW:0]   arb_rel;
    logic          legal;

    always_comb begin
        nxt_ptr     = (gnt_id == IW'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
        release_now = bus.done || !bus.req[gnt_id];
        revoke      = (MAX_HOLD != 0) && (hold_cnt == HW'(MAX_HOLD)) && !release_now;
        arb_idle    = pick(bus.req, ptr);
        arb_rel     = pick(bus.req, nxt_ptr);
        legal       = ((gnt == '0) && (state == IDLE)) ||
                      ((gnt != '0) && ((gnt & (gnt - 1'b1)) == '0) && (state == GRANT));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            gnt      <= '0;
            gnt_id   <= '0;
            timeout  <= 1'b0;
            err      <= 1'b0;
        end else begin
            timeout <= 1'b0;
            err     <= err | !legal;
            case (state)
                IDLE: begin
                    if (arb_idle[IW]) begin
                        state    <= GRANT;
                        gnt      <= NUM_REQ'(1) << arb_idle[IW-1:0];
                        gnt_id   <= arb_idle[IW-1:0];
                        hold_cnt <= HW'(1);
                    end
                end
                GRANT: begin
                    if (release_now || revoke) begin
                        // Owner drops to lowest priority before re-arbitrating.
                        ptr     <= nxt_ptr;
                        timeout <= revoke;
                        if (arb_rel[IW]) begin
                            gnt      <= NUM_REQ'(1) << arb_rel[IW-1:0];
                            gnt_id   <= arb_rel[IW-1:0];
                            hold_cnt <= HW'(1);
                        end else begin
                            state    <= IDLE;
                            gnt      <= '0;
                            gnt_id   <= '0;
                            hold_cnt <= '0;
                        end
                    end else if (MAX_HOLD != 0 && hold_cnt != HW'(MAX_HOLD)) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt     = gnt;
    assign bus.gnt_id  = gnt_id;
    assign bus.busy    = |gnt;
    assign bus.timeout = timeout;
    assign bus.err     = err;
endmodule
